// File: rtl/hs_frame_aligner_pkg.sv
// Shared types and helpers for the 64b/66b sync-header frame aligner.
package hs_align_pkg;

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} align_state_e;

    localparam int POS_W = 7;

    function automatic logic hdr_valid(input logic [1:0] hdr);
        return (hdr == 2'b01) || (hdr == 2'b10);
    endfunction

    // Number of candidate positions k, k+n_seek, ... below frame_w.
    function automatic int seeker_span(input int k, input int n_seek, input int frame_w);
        return (frame_w - k + n_seek - 1) / n_seek;
    endfunction

endpackage

// File: rtl/hs_frame_aligner_header_seeker.sv
// One stride-interleaved seeker: walks its own header positions until it
// sees LOCK_CNT consecutive valid headers at one of them.
module header_seeker
    import hs_align_pkg::*;
#(
    parameter int INIT_POS = 0,
    parameter int STRIDE   = 1,
    parameter int FRAME_W  = 66,
    parameter int LOCK_CNT = 32,
    parameter int BUF_W    = 194
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dv_i,
    input  logic             freeze_i,
    input  logic             clear_i,
    input  logic [BUF_W-1:0] buf_i,
    output logic [POS_W-1:0] pos_o,
    output logic             found_o
);

    localparam int CNT_W    = $clog2(LOCK_CNT + 1);
    localparam int IDX_W    = $clog2(BUF_W);
    localparam int LAST_POS = INIT_POS + (seeker_span(INIT_POS, STRIDE, FRAME_W) - 1) * STRIDE;

    logic [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx;
    logic [1:0]       hdr;

    assign idx = IDX_W'(pos_q);
    assign hdr = buf_i[idx +: 2];

    always_comb begin
        pos_d = pos_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            pos_d = POS_W'(INIT_POS);
            cnt_d = '0;
        end else if (dv_i && !freeze_i) begin
            if (hdr_valid(hdr)) begin
                if (cnt_q != CNT_W'(LOCK_CNT)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = '0;
                pos_d = (pos_q == POS_W'(LAST_POS)) ? POS_W'(INIT_POS) : pos_q + POS_W'(STRIDE);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pos_q <= POS_W'(INIT_POS);
            cnt_q <= '0;
        end else begin
            pos_q <= pos_d;
            cnt_q <= cnt_d;
        end
    end

    assign pos_o   = pos_q;
    assign found_o = (cnt_q == CNT_W'(LOCK_CNT));

endmodule

// File: rtl/hs_frame_aligner.sv
// Sync-header frame aligner: seeker bank with sticky arbitration, plus a
// windowed error monitor that drops lock and relocks automatically.
module hs_frame_aligner
    import hs_align_pkg::*;
#(
    parameter int FRAME_W    = 66,
    parameter int BUF_W      = 194,
    parameter int N_SEEK     = 2,
    parameter int LOCK_CNT   = 32,
    parameter int UNLOCK_WIN = 64,
    parameter int UNLOCK_ERR = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [BUF_W-1:0] gbox_buffer,
    input  logic             buffer_dv,
    output logic             is_synced,
    output logic [6:0]       offset_pos,
    output logic             lock_lost,
    output logic [15:0]      n_relock
);

    localparam int WIN_W = $clog2(UNLOCK_WIN + 1);
    localparam int ERR_W = $clog2(UNLOCK_ERR + 1);
    localparam int IDX_W = $clog2(BUF_W);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    align_state_e     state_q, state_d;
    logic             synced_q, synced_d;
    logic [POS_W-1:0] offset_q, offset_d;
    logic [POS_W-1:0] last_win_q, last_win_d;
    logic             lock_lost_q, lock_lost_d;
    logic [15:0]      n_relock_q, n_relock_d;
    logic [WIN_W-1:0] win_q, win_d, win_inc;
    logic [ERR_W-1:0] err_q, err_d, err_inc;

    logic [POS_W-1:0] seek_pos [N_SEEK];
    logic [N_SEEK-1:0] seek_found;
    logic             seek_freeze, seek_clear;
    logic             win_found;
    logic [POS_W-1:0] win_idx, win_pos;
    logic [IDX_W-1:0] mon_idx;
    logic [1:0]       mon_hdr;

    assign seek_freeze = (state_q == LOCKED);

    for (genvar k = 0; k < N_SEEK; k++) begin : g_seek
        header_seeker #(
            .INIT_POS (k),
            .STRIDE   (N_SEEK),
            .FRAME_W  (FRAME_W),
            .LOCK_CNT (LOCK_CNT),
            .BUF_W    (BUF_W)
        ) u_seek (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .dv_i     (buffer_dv),
            .freeze_i (seek_freeze),
            .clear_i  (seek_clear),
            .buf_i    (gbox_buffer),
            .pos_o    (seek_pos[k]),
            .found_o  (seek_found[k])
        );
    end

    // Lowest-index found seeker wins unless the previous winner is found again.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_pos   = '0;
        for (int j = N_SEEK - 1; j >= 0; j--) begin
            if (seek_found[j]) begin
                win_found = 1'b1;
                win_idx   = POS_W'(j);
                win_pos   = seek_pos[j];
            end
        end
        for (int j = 0; j < N_SEEK; j++) begin
            if (seek_found[j] && (POS_W'(j) == last_win_q)) begin
                win_idx = POS_W'(j);
                win_pos = seek_pos[j];
            end
        end
    end

    assign mon_idx = IDX_W'(offset_q);
    assign mon_hdr = gbox_buffer[mon_idx +: 2];

    always_comb begin
        state_d     = state_q;
        synced_d    = synced_q;
        offset_d    = offset_q;
        last_win_d  = last_win_q;
        lock_lost_d = 1'b0;
        n_relock_d  = n_relock_q;
        win_d       = win_q;
        err_d       = err_q;
        seek_clear  = 1'b0;
        win_inc     = win_q + WIN_W'(1);
        err_inc     = err_q + (hdr_valid(mon_hdr) ? ERR_W'(0) : ERR_W'(1));
        case (state_q)
            SEARCH: begin
                if (win_found) begin
                    state_d    = LOCKED;
                    synced_d   = 1'b1;
                    offset_d   = win_pos;
                    last_win_d = win_idx;
                    win_d      = '0;
                    err_d      = '0;
                end
            end
            LOCKED: begin
                if (buffer_dv) begin
                    if (err_inc == ERR_W'(UNLOCK_ERR)) begin
                        state_d     = SEARCH;
                        synced_d    = 1'b0;
                        lock_lost_d = 1'b1;
                        n_relock_d  = sat_inc16(n_relock_q);
                        seek_clear  = 1'b1;
                    end else if (win_inc == WIN_W'(UNLOCK_WIN)) begin
                        win_d = '0;
                        err_d = '0;
                    end else begin
                        win_d = win_inc;
                        err_d = err_inc;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= SEARCH;
            synced_q    <= 1'b0;
            offset_q    <= '0;
            last_win_q  <= '0;
            lock_lost_q <= 1'b0;
            n_relock_q  <= '0;
            win_q       <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            synced_q    <= synced_d;
            offset_q    <= offset_d;
            last_win_q  <= last_win_d;
            lock_lost_q <= lock_lost_d;
            n_relock_q  <= n_relock_d;
            win_q       <= win_d;
            err_q       <= err_d;
        end
    end

    assign is_synced  = synced_q;
    assign offset_pos = offset_q;
    assign lock_lost  = lock_lost_q;
    assign n_relock   = n_relock_q;

endmodule
